// File: rtl/tx_arb_fifo_if.sv
// Bundles the channel-side record inputs and UART-side signals of tx_arb_fifo.
// The prio_mask input exists only when TX_ARB_PRIORITY_EN is defined.
interface tx_arb_fifo_if #(
    parameter int NUM_CH = 4
);
    logic [8*NUM_CH-1:0]  tx_addr_in;
    logic [8*NUM_CH-1:0]  tx_buysell_in;
    logic [32*NUM_CH-1:0] tx_timestamp_in;
    logic [NUM_CH-1:0]    tx_dv_in;
    logic [NUM_CH-1:0]    fifo_full;
    logic [NUM_CH-1:0]    overflow;
    logic                 ack_err;
    logic [7:0]           tx_addr;
    logic [7:0]           tx_buysell;
    logic [31:0]          tx_timestamp;
    logic                 tx_dv;
    logic                 tx_busy;
`ifdef TX_ARB_PRIORITY_EN
    logic [NUM_CH-1:0]    prio_mask;
`endif

    modport master (
`ifdef TX_ARB_PRIORITY_EN
        output prio_mask,
`endif
        output tx_addr_in, output tx_buysell_in, output tx_timestamp_in,
        output tx_dv_in, output tx_busy,
        input  fifo_full, input overflow, input ack_err,
        input  tx_addr, input tx_buysell, input tx_timestamp, input tx_dv
    );

    modport slave (
`ifdef TX_ARB_PRIORITY_EN
        input  prio_mask,
`endif
        input  tx_addr_in, input tx_buysell_in, input tx_timestamp_in,
        input  tx_dv_in, input tx_busy,
        output fifo_full, output overflow, output ack_err,
        output tx_addr, output tx_buysell, output tx_timestamp, output tx_dv
    );
endinterface

// File: rtl/tx_arb_fifo.sv
// Per-channel record FIFOs feeding a round-robin arbiter to one UART TX (TX_ARB_PRIORITY_EN adds prio_mask classes).
// Latency: strobe at edge E0 -> tx_dv high after E3 when idle; tx_dv held HOLD_CYCLES per record.
// Backpressure: no grant while tx_busy is high; a strobe into a full FIFO is dropped and flags overflow.
module tx_arb_fifo #(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    tx_arb_fifo_if.slave bus
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam int AW  = $clog2(ACK_TIMEOUT + 1);

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  buysell;
        logic [31:0] ts;
    } rec_t;

    typedef enum logic [2:0] {IDLE, LOAD, DRIVE, WAIT_ACK, WAIT_IDLE} state_t;

    rec_t              mem [NUM_CH][FIFO_DEPTH];
    rec_t              in_dat_q [NUM_CH];
    logic [NUM_CH-1:0] in_vld_q;
    logic [PW-1:0]     wr_ptr [NUM_CH];
    logic [PW-1:0]     rd_ptr [NUM_CH];
    logic [CW-1:0]     cnt [NUM_CH];
    logic [CW-1:0]     cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] full_q, nonempty, push, pop, req, overflow_q;

    state_t            state;
    rec_t              rd_dat;
    logic [CHW-1:0]    rr_ptr, grant, rr_nxt;
    logic              grant_vld;
    logic [HW-1:0]     hold_cnt;
    logic [AW-1:0]     ack_cnt;
    logic              ack_err_q, tx_dv_q;
    rec_t              tx_rec_q;
    int                idx;

    // Strobes are captured into a register stage before the FIFO write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_dat_q[i] <= '{addr:    bus.tx_addr_in[8*i +: 8],
                             buysell: bus.tx_buysell_in[8*i +: 8],
                             ts:      bus.tx_timestamp_in[32*i +: 32]};
            if (push[i])
                mem[i][wr_ptr[i]] <= in_dat_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (cnt[i] != '0);
            push[i]     = in_vld_q[i] && !full_q[i];
            pop[i]      = (state == IDLE) && !bus.tx_busy && grant_vld && (grant == CHW'(i));
            cnt_nxt[i]  = cnt[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_vld_q   <= '0;
            full_q     <= '0;
            overflow_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            in_vld_q <= bus.tx_dv_in;
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                cnt[i]    <= cnt_nxt[i];
                full_q[i] <= (cnt_nxt[i] == CW'(FIFO_DEPTH));
                if (in_vld_q[i] && full_q[i])
                    overflow_q[i] <= 1'b1;
            end
        end
    end

    // Cyclic search from rr_ptr; the priority class, when present, narrows the request set first.
    always_comb begin
        req = nonempty;
`ifdef TX_ARB_PRIORITY_EN
        if (|(nonempty & bus.prio_mask))
            req = nonempty & bus.prio_mask;
`endif
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant     = CHW'(idx);
            end
        end
        rr_nxt = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rd_dat    <= '0;
            tx_rec_q  <= '0;
            tx_dv_q   <= 1'b0;
            hold_cnt  <= '0;
            ack_cnt   <= '0;
            ack_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.tx_busy && grant_vld) begin
                        rd_dat <= mem[grant][rd_ptr[grant]];
                        rr_ptr <= rr_nxt;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    tx_rec_q <= rd_dat;
                    tx_dv_q  <= 1'b1;
                    hold_cnt <= HW'(1);
                    state    <= DRIVE;
                end
                DRIVE: begin
                    if (hold_cnt == HW'(HOLD_CYCLES)) begin
                        tx_rec_q <= '0;
                        tx_dv_q  <= 1'b0;
                        ack_cnt  <= '0;
                        state    <= WAIT_ACK;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_IDLE;
                    end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        ack_err_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (!bus.tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_full    = full_q;
    assign bus.overflow     = overflow_q;
    assign bus.ack_err      = ack_err_q;
    assign bus.tx_addr      = tx_rec_q.addr;
    assign bus.tx_buysell   = tx_rec_q.buysell;
    assign bus.tx_timestamp = tx_rec_q.ts;
    assign bus.tx_dv        = tx_dv_q;
endmodule
